// File: rtl/rtlola_eval_scheduler.sv
// Evaluation scheduler for the RTLola monitor.
// Merges input events and periodic deadlines into timestamped entries, queues
// them, and replays each entry as a three-layer evaluation:
// input layer (L0), event outputs (L1), periodic outputs (L2).
// Handshake: q_push is asserted whenever an entry is offered; q_push_valid
// means it was written into the queue this cycle. q_pop is asserted only when
// the queue holds at least one entry, so every pop completes and q_pop_valid
// mirrors it. Both are gated by en, since nothing moves in a frozen cycle.
module rtlola_eval_scheduler #(
  parameter int         TS_WIDTH = 64,
  parameter int         Q_DEPTH  = 4,
  parameter int         PERIOD_2 = 1000,
  parameter int         PERIOD_3 = 500,
  parameter logic [1:0] ACT_OUT0 = 2'b01,
  parameter logic [1:0] ACT_OUT1 = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                new_input_0,
  input  logic                new_input_1,
  output logic                q_push,
  output logic                q_push_valid,
  output logic                q_pop,
  output logic                q_pop_valid,
  output logic                q_overflow,
  output logic [TS_WIDTH-1:0] ev_timestamp,
  output logic                enable_in0,
  output logic                enable_in1,
  output logic                enable_out0,
  output logic                enable_out1,
  output logic                enable_out2,
  output logic                enable_out3,
  output logic [1:0]          fsm_state
);

  localparam int AW  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int C2W = $clog2(PERIOD_2);
  localparam int C3W = $clog2(PERIOD_3);
  localparam int EW  = TS_WIDTH + 4;
  localparam logic [C2W-1:0] LAST2 = C2W'(PERIOD_2 - 1);
  localparam logic [C3W-1:0] LAST3 = C3W'(PERIOD_3 - 1);
  localparam logic [CW-1:0]  DEPTH = CW'(Q_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, L0 = 2'd1, L1 = 2'd2, L2 = 2'd3} state_t;

  logic [TS_WIDTH-1:0] ts;
  logic [C2W-1:0]      cnt2;
  logic [C3W-1:0]      cnt3;
  logic [EW-1:0]       mem [Q_DEPTH];
  logic [AW-1:0]       wp, rp;
  logic [CW-1:0]       count;
  state_t              state, next_state;
  logic [1:0]          ev_in, ev_per;
  logic [1:0]          in_mask, per_mask;

  assign in_mask  = {new_input_1, new_input_0};
  assign per_mask = {cnt3 == LAST3, cnt2 == LAST2};

  assign q_push       = en & (|{in_mask, per_mask});
  assign q_pop        = en & (count != '0) & ((state == IDLE) | (state == L2));
  assign q_pop_valid  = q_pop;
  assign q_push_valid = q_push & ((count < DEPTH) | q_pop);

  assign fsm_state = state;

  // Free-running timestamp and deadline counters, frozen when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts   <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (en) begin
      ts   <= ts + TS_WIDTH'(1);
      cnt2 <= (cnt2 == LAST2) ? '0 : cnt2 + C2W'(1);
      cnt3 <= (cnt3 == LAST3) ? '0 : cnt3 + C3W'(1);
    end
  end

  // Queue storage; contents need no reset because pointers and count do.
  always_ff @(posedge clk) begin
    if (q_push_valid) mem[wp] <= {ts, in_mask, per_mask};
  end

  // Queue pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      q_overflow <= 1'b0;
    end else if (en) begin
      if (q_push_valid) wp <= wp + AW'(1);
      if (q_pop)        rp <= rp + AW'(1);
      case ({q_push_valid, q_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (q_push & ~q_push_valid) q_overflow <= 1'b1;
    end
  end

  // Evaluator state register.
  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (en) state <= next_state;
  end

  // Evaluator next state: a pop always starts a new pass at L0.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = q_pop ? L0 : IDLE;
      L0:      next_state = L1;
      L1:      next_state = L2;
      L2:      next_state = q_pop ? L0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Eval register: latches the popped entry for the three layers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_timestamp <= '0;
      ev_in        <= '0;
      ev_per       <= '0;
    end else if (en && q_pop) begin
      {ev_timestamp, ev_in, ev_per} <= mem[rp];
    end
  end

  // Layer strobes decoded from registered state and the eval register.
  always_comb begin
    enable_in0  = (state == L0) & ev_in[0];
    enable_in1  = (state == L0) & ev_in[1];
    enable_out0 = (state == L1) & (&(ev_in | ~ACT_OUT0)) & (|(ev_in & ACT_OUT0));
    enable_out1 = (state == L1) & (&(ev_in | ~ACT_OUT1)) & (|(ev_in & ACT_OUT1));
    enable_out2 = (state == L2) & ev_per[0];
    enable_out3 = (state == L2) & ev_per[1];
  end

endmodule
